// File: rtl/sigma1_inverse.sv
// Iterative SHA-256 big-sigma-1 engine: one application of Sigma1 per clock,
// once for the forward function or fifteen times for its exact inverse.
module sigma1_inverse (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_inverse,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] FwdIters = 4'd1;
  localparam logic [3:0] InvIters = 4'd15;

  logic [1:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] work_q, work_d;
  logic [31:0] sigmaWork;

  // Sigma1^16 is the identity, so fifteen passes through this network invert it.
  assign sigmaWork = {work_q[5:0],  work_q[31:6]}  ^
                     {work_q[10:0], work_q[31:11]} ^
                     {work_q[24:0], work_q[31:25]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    work_d  = work_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_data;
          count_d = in_inverse ? InvIters : FwdIters;
          state_d = StBusy;
        end
      end
      StBusy: begin
        work_d  = sigmaWork;
        count_d = count_q - 4'd1;
        // A zero count is unreachable; treating it as final keeps the engine from looping.
        if (count_q <= 4'd1) begin
          count_d = 4'd0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      work_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy);
  assign out_data  = work_q;

endmodule
